stream_demux: RTL and testbench

STREAM_DEMUX -- requirements
Module: stream_demux

---
 rtl/stream_demux_pkg.sv | 17 +
 rtl/stream_demux_dest_decode.sv | 20 ++
 rtl/stream_demux.sv | 126 ++++++++++++
 tb/tb_stream_demux.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/stream_demux_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// stream_demux_pkg : shared FSM encoding and counter width for stream_demux
// Rev 1.0
// ----------------------------------------------------------------------------
package stream_demux_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    STALL = 2'd2
  } state_e;

  localparam int DROP_CNT_W = 8;

endpackage
`default_nettype wire

// File: rtl/stream_demux_dest_decode.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dest_decode : 2-bit channel index plus valid to N_OUT-bit one-hot vector
// Rev 1.0
// ----------------------------------------------------------------------------
module dest_decode #(
  parameter int N_OUT = 4
) (
  input  logic [1:0]       idx,
  input  logic             valid,
  output logic [N_OUT-1:0] onehot
);

  // Indices at or above N_OUT match no bit, so the vector is all zero.
  for (genvar i = 0; i < N_OUT; i++) begin : g_bit
    assign onehot[i] = valid && (idx == 2'(i));
  end

endmodule
`default_nettype wire

// File: rtl/stream_demux.sv
`default_nettype none
// ----------------------------------------------------------------------------
// stream_demux : one-input, N_OUT-output stream demultiplexer with skid buffer
// Rev 1.0
// ----------------------------------------------------------------------------
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int N_OUT  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [1:0]            in_dest,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [N_OUT-1:0]      out_valid,
  input  logic [N_OUT-1:0]      out_ready,
  output logic [DROP_CNT_W-1:0] drop_cnt,
  output logic                  busy
);

  localparam logic [2:0] N_OUT_U = 3'(N_OUT);

  state_e                  state_q, state_d;
  logic                    in_ready_q, in_ready_d;
  logic [DATA_W-1:0]       main_data_q, main_data_d;
  logic [1:0]              main_dest_q, main_dest_d;
  logic [DATA_W-1:0]       skid_data_q, skid_data_d;
  logic [1:0]              skid_dest_q, skid_dest_d;
  logic [DROP_CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

  logic in_xfer;
  logic in_range;
  logic load;
  logic out_xfer;

  assign in_xfer  = in_valid && in_ready_q;
  assign in_range = ({1'b0, in_dest} < N_OUT_U);
  assign load     = in_xfer && in_range;
  assign busy     = (state_q != IDLE);

  dest_decode #(
    .N_OUT (N_OUT)
  ) u_dest_decode (
    .idx    (main_dest_q),
    .valid  (busy),
    .onehot (out_valid)
  );

  // Only the addressed channel can produce a transfer; other ready bits are masked.
  assign out_xfer = |(out_valid & out_ready);
  assign out_data = main_data_q;
  assign in_ready = in_ready_q;
  assign drop_cnt = drop_cnt_q;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_dest_d = main_dest_q;
    skid_data_d = skid_data_q;
    skid_dest_d = skid_dest_q;
    drop_cnt_d  = drop_cnt_q;

    if (in_xfer && !in_range && (drop_cnt_q != {DROP_CNT_W{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (load) begin
          main_data_d = in_data;
          main_dest_d = in_dest;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (out_xfer && load) begin
          main_data_d = in_data;
          main_dest_d = in_dest;
        end else if (out_xfer) begin
          state_d = IDLE;
        end else if (load) begin
          skid_data_d = in_data;
          skid_dest_d = in_dest;
          state_d     = STALL;
        end
      end
      STALL: begin
        if (out_xfer) begin
          main_data_d = skid_data_q;
          main_dest_d = skid_dest_q;
          state_d     = BUSY;
        end
      end
      default: state_d = IDLE;
    endcase

    // Registered ready: look ahead at the next state so it is valid from the edge.
    in_ready_d = (state_d != STALL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      main_data_q <= '0;
      main_dest_q <= '0;
      skid_data_q <= '0;
      skid_dest_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      main_data_q <= main_data_d;
      main_dest_q <= main_dest_d;
      skid_data_q <= skid_data_d;
      skid_dest_q <= skid_dest_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stream_demux.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_stream_demux : directed self-checking bench for stream_demux (N_OUT=4 and 3)
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_stream_demux;

  logic clk;
  logic rst;

  logic [31:0] a_in_data;
  logic [1:0]  a_in_dest;
  logic        a_in_valid;
  logic        a_in_ready;
  logic [31:0] a_out_data;
  logic [3:0]  a_out_valid;
  logic [3:0]  a_out_ready;
  logic [7:0]  a_drop_cnt;
  logic        a_busy;

  logic [31:0] b_in_data;
  logic [1:0]  b_in_dest;
  logic        b_in_valid;
  logic        b_in_ready;
  logic [31:0] b_out_data;
  logic [2:0]  b_out_valid;
  logic [2:0]  b_out_ready;
  logic [7:0]  b_drop_cnt;
  logic        b_busy;

  int n_pass  = 0;
  int n_total = 0;
  logic seen_valid;

  stream_demux #(.DATA_W(32), .N_OUT(4)) u_dut_a (
    .clk       (clk),
    .rst       (rst),
    .in_data   (a_in_data),
    .in_dest   (a_in_dest),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .out_data  (a_out_data),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .drop_cnt  (a_drop_cnt),
    .busy      (a_busy)
  );

  stream_demux #(.DATA_W(32), .N_OUT(3)) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_data   (b_in_data),
    .in_dest   (b_in_dest),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .out_data  (b_out_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .drop_cnt  (b_drop_cnt),
    .busy      (b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the full visible state of DUT A in one call.
  task automatic chk_a(input string tag, input logic [3:0] ov, input logic [31:0] od,
                       input logic rdy, input logic bsy);
    chk({tag, ".out_valid"}, {28'd0, a_out_valid}, {28'd0, ov});
    if (ov != 4'd0) chk({tag, ".out_data"}, a_out_data, od);
    chk({tag, ".in_ready"}, {31'd0, a_in_ready}, {31'd0, rdy});
    chk({tag, ".busy"}, {31'd0, a_busy}, {31'd0, bsy});
  endtask

  task automatic drive_a(input logic v, input logic [1:0] d, input logic [31:0] x);
    a_in_valid = v;
    a_in_dest  = d;
    a_in_data  = x;
  endtask

  initial begin
    rst = 1'b0;
    drive_a(1'b0, 2'd0, 32'd0);
    a_out_ready = 4'h0;
    b_in_valid  = 1'b0;
    b_in_dest   = 2'd0;
    b_in_data   = 32'd0;
    b_out_ready = 3'h0;

    // Power-up reset, checked before any clock edge.
    #1 rst = 1'b1;
    #1;
    chk("rst0.out_valid", {28'd0, a_out_valid}, 32'd0);
    chk("rst0.out_data", a_out_data, 32'd0);
    chk("rst0.in_ready", {31'd0, a_in_ready}, 32'd1);
    chk("rst0.drop_cnt", {24'd0, a_drop_cnt}, 32'd0);
    chk("rst0.busy", {31'd0, a_busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Streaming: one beat per cycle across all four channels.
    a_out_ready = 4'hF;
    drive_a(1'b1, 2'd0, 32'hA0);
    tick(); chk_a("strm0", 4'b0001, 32'hA0, 1'b1, 1'b1);
    drive_a(1'b1, 2'd1, 32'hA1);
    tick(); chk_a("strm1", 4'b0010, 32'hA1, 1'b1, 1'b1);
    drive_a(1'b1, 2'd2, 32'hA2);
    tick(); chk_a("strm2", 4'b0100, 32'hA2, 1'b1, 1'b1);
    drive_a(1'b1, 2'd3, 32'hA3);
    tick(); chk_a("strm3", 4'b1000, 32'hA3, 1'b1, 1'b1);
    drive_a(1'b0, 2'd0, 32'h0);
    tick(); chk_a("strm_end", 4'b0000, 32'h0, 1'b1, 1'b0);

    // Backpressure on channel 2 with two queued beats.
    a_out_ready = 4'b1011;
    drive_a(1'b1, 2'd2, 32'h11);
    tick(); chk_a("bp0", 4'b0100, 32'h11, 1'b1, 1'b1);
    drive_a(1'b1, 2'd2, 32'h22);
    tick(); chk_a("bp_stall", 4'b0100, 32'h11, 1'b0, 1'b1);
    drive_a(1'b1, 2'd0, 32'h99);
    tick(); chk_a("bp_hold", 4'b0100, 32'h11, 1'b0, 1'b1);
    drive_a(1'b0, 2'd0, 32'h0);
    a_out_ready = 4'hF;
    tick(); chk_a("bp_rel1", 4'b0100, 32'h22, 1'b1, 1'b1);
    tick(); chk_a("bp_rel2", 4'b0000, 32'h0, 1'b1, 1'b0);

    // Head-of-line: stalled dest 1 blocks a ready dest 0.
    a_out_ready = 4'b1101;
    drive_a(1'b1, 2'd1, 32'h31);
    tick(); chk_a("hol0", 4'b0010, 32'h31, 1'b1, 1'b1);
    drive_a(1'b1, 2'd0, 32'h40);
    tick(); chk_a("hol_stall", 4'b0010, 32'h31, 1'b0, 1'b1);
    drive_a(1'b0, 2'd0, 32'h0);
    tick(); chk_a("hol_hold", 4'b0010, 32'h31, 1'b0, 1'b1);
    a_out_ready = 4'hF;
    tick(); chk_a("hol_rel1", 4'b0001, 32'h40, 1'b1, 1'b1);
    tick(); chk_a("hol_rel2", 4'b0000, 32'h0, 1'b1, 1'b0);

    // Simultaneous output transfer and load in BUSY.
    drive_a(1'b1, 2'd3, 32'h55);
    tick(); chk_a("sim0", 4'b1000, 32'h55, 1'b1, 1'b1);
    drive_a(1'b1, 2'd0, 32'h66);
    tick(); chk_a("sim1", 4'b0001, 32'h66, 1'b1, 1'b1);
    drive_a(1'b0, 2'd0, 32'h0);
    tick(); chk_a("sim_end", 4'b0000, 32'h0, 1'b1, 1'b0);

    // Drop path on the 3-channel instance: 257 beats to dest 3.
    b_out_ready = 3'b111;
    b_in_valid  = 1'b1;
    b_in_dest   = 2'd3;
    b_in_data   = 32'hDEAD;
    seen_valid  = 1'b0;
    for (int k = 0; k < 257; k++) begin
      tick();
      if (b_out_valid != 3'd0) seen_valid = 1'b1;
      if (k == 0)   chk("drop_first", {24'd0, b_drop_cnt}, 32'd1);
      if (k == 253) chk("drop_254", {24'd0, b_drop_cnt}, 32'd254);
    end
    chk("drop_sat", {24'd0, b_drop_cnt}, 32'd255);
    chk("drop_no_valid", {31'd0, seen_valid}, 32'd0);
    chk("drop_idle_busy", {31'd0, b_busy}, 32'd0);
    chk("drop_idle_rdy", {31'd0, b_in_ready}, 32'd1);
    b_in_dest = 2'd2;
    b_in_data = 32'h77;
    tick();
    chk("drop_after_valid", {29'd0, b_out_valid}, 32'd4);
    chk("drop_after_data", b_out_data, 32'h77);
    b_in_valid = 1'b0;
    tick();

    // Reset asserted mid-STALL between clock edges.
    a_out_ready = 4'h0;
    drive_a(1'b1, 2'd2, 32'h77);
    tick(); chk_a("rs0", 4'b0100, 32'h77, 1'b1, 1'b1);
    drive_a(1'b1, 2'd3, 32'h88);
    tick(); chk_a("rs_stall", 4'b0100, 32'h77, 1'b0, 1'b1);
    drive_a(1'b0, 2'd0, 32'h0);
    #2 rst = 1'b1;
    #1;
    chk("rst1.out_valid", {28'd0, a_out_valid}, 32'd0);
    chk("rst1.out_data", a_out_data, 32'd0);
    chk("rst1.in_ready", {31'd0, a_in_ready}, 32'd1);
    chk("rst1.busy", {31'd0, a_busy}, 32'd0);
    chk("rst1.drop_cnt_b", {24'd0, b_drop_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    a_out_ready = 4'hF;
    tick(); chk_a("rs_after", 4'b0000, 32'h0, 1'b1, 1'b0);
    drive_a(1'b1, 2'd1, 32'h5A);
    tick(); chk_a("rs_first", 4'b0010, 32'h5A, 1'b1, 1'b1);
    drive_a(1'b0, 2'd0, 32'h0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
